led_pattern_sched: RTL and testbench
====================================

// Module: led_pattern_sched
// PURPOSE
//  Shares one board LED among NREQ requesters; each plays a counted blink code.
//  Round-robin arbiter grants the LED; FSM runs N flashes, a gap, then releases.
//  Timebase from a prescaled tick derived from OSC_CLOCK; sits between status sources and the LED pin.
// PARAMETERS
//  OSC_CLOCK  27000000  input clock frequency, Hz
//  TICK_HZ    100       tick rate; TICK_DIV = OSC_CLOCK/TICK_HZ clocks per tick (integer divide)
//  NREQ       4         number of requesters (2..8)
//  ON_TICKS   25        ticks LED held on per flash (>=1)
//  OFF_TICKS  25        ticks LED held off between flashes (>=1)
//  GAP_TICKS  100       ticks of dark gap after the last flash (>=1)
// PORTS
//  in_clk     in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  req        in   NREQ    level request per requester; held until done or abandoned
//  blink_cnt  in   4*NREQ  flash count per requester, nibble i for req[i]; 0 treated as 1
//  led        out  1       LED drive, 1 = on
//  grant      out  NREQ    one-hot owner of the LED; all-zero when idle
//  busy       out  1       1 while any sequence is running (state != IDLE)
//  done       out  1       one-cycle pulse when a sequence completes normally
// BEHAVIOUR
//  Reset: state=IDLE, led=0, grant=0, busy=0, done=0, prescaler=0, phase=0, rr_ptr=0, remaining=0.
//  Prescaler: counts 0..TICK_DIV-1; tick=1 on the clock where it equals TICK_DIV-1; cleared on every grant.
//  phase counter (16b) counts ticks in the current state; cleared on every state change.
//  FSM states: IDLE, ON, OFF, GAP.
//  IDLE: any req set -> pick first set bit searching from rr_ptr upward, wrapping at NREQ.
//   Next edge: grant=onehot(winner), busy=1, led=1, remaining=max(blink_cnt[winner],1), state=ON.
//   rr_ptr <= winner+1 (mod NREQ) at grant time; simultaneous requests resolved by that search.
//  ON: led=1; after ON_TICKS ticks -> OFF, remaining decremented.
//  OFF: led=0; after OFF_TICKS ticks -> ON if remaining!=0, else GAP.
//  GAP: led=0; after GAP_TICKS ticks -> IDLE, done=1 for that single clock, grant=0, busy=0.
//  Abandon: owner's req falls in ON/OFF/GAP -> next edge IDLE, led=0, grant=0, busy=0, no done.
//  Other requesters never preempt; they wait in IDLE arbitration. Requests changing on a
//   transition clock are sampled only in IDLE.
//  blink_cnt sampled once at grant; later changes ignored until next grant.
//  IDLE->grant latency: 1 clock. Same requester re-requesting after done is re-arbitrated
//   in IDLE (minimum 1 IDLE clock between sequences), rr_ptr ensures others go first.
//  Sequence duration (cycles from grant): TICK_DIV*(N*(ON_TICKS+OFF_TICKS)+GAP_TICKS).
//  Reset mid-sequence: immediate return to reset values, no done pulse.
// CONFIGURATION
//  LED_IDLE_HEARTBEAT_EN defined: in IDLE with req==0, led toggles every TICK_HZ/2 ticks
//   (1 Hz heartbeat); heartbeat counter frozen during sequences and restarted, led=0, on entry to IDLE.
//  Not defined: led=0 throughout IDLE; no heartbeat logic synthesised.
// TESTING  (bench params: OSC_CLOCK=100, TICK_HZ=10 -> TICK_DIV=10; ON=2, OFF=2, GAP=3, NREQ=4)
//  Reset: assert reset mid-ON -> led=0, grant=0, busy=0 asynchronously; no done after release.
//  Single: req[0]=1, blink_cnt[0]=2 -> grant=0001 next edge; led high 20, low 20, high 20,
//   low 50 clocks; done pulse at clock 110 after grant; grant=0 same edge.
//  Zero count: req[1], blink_cnt=0 -> exactly one 20-clock flash, done at clock 70.
//  Round-robin: req=1111 held, counts=1 -> grants in order 0001,0010,0100,1000,0001.
//  Abandon: drop req[2] during its OFF phase -> led=0, grant=0 next edge, no done; req[3] granted after.
//  Heartbeat (LED_IDLE_HEARTBEAT_EN): req=0 -> led toggles every 50 clocks; without macro led stays 0.

Source files
------------

// File: rtl/led_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sched
// Description : Shares one LED among NREQ requesters. A round-robin arbiter
//               grants the LED, then a blink code of N flashes and a dark gap
//               is played. Optional idle heartbeat: LED_IDLE_HEARTBEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sched #(
    parameter int OSC_CLOCK = 27000000,
    parameter int TICK_HZ   = 100,
    parameter int NREQ      = 4,
    parameter int ON_TICKS  = 25,
    parameter int OFF_TICKS = 25,
    parameter int GAP_TICKS = 100
) (
    input  logic              in_clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] blink_cnt,
    output logic              led,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              done
);

    localparam int c_TICK_DIV = (OSC_CLOCK / TICK_HZ < 1) ? 1 : OSC_CLOCK / TICK_HZ;
    localparam int c_PW       = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam int c_IW       = $clog2(NREQ);
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(c_TICK_DIV - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ON   = 2'd1;
    localparam logic [1:0] c_ST_OFF  = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

`ifdef LED_IDLE_HEARTBEAT_EN
    localparam int c_HB_TICKS = (TICK_HZ / 2 < 1) ? 1 : TICK_HZ / 2;
    localparam logic [15:0] c_HB_MAX = 16'(c_HB_TICKS - 1);
    logic [15:0] r_hb_cnt;
`endif

    logic [1:0]      r_state;
    logic [c_PW-1:0] r_presc;
    logic [15:0]     r_phase;
    logic [c_IW-1:0] r_rr_ptr;
    logic [3:0]      r_remaining;

    logic            w_tick;
    logic            w_phase_done;
    logic            w_found;
    logic            w_owner_req;
    logic [c_IW-1:0] w_winner;
    logic [c_IW-1:0] w_idx;
    logic [c_IW-1:0] w_next_ptr;
    logic [3:0]      w_nibble;
    logic [3:0]      w_count;
    logic [15:0]     w_limit;

    assign w_tick      = (r_presc == c_PRESC_MAX);
    assign w_owner_req = |(req & grant);

    // First set request at or after the round-robin pointer, wrapping at NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = c_IW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_next_ptr = (w_winner == c_IW'(NREQ - 1)) ? '0 : w_winner + c_IW'(1);
    assign w_nibble   = blink_cnt[{w_winner, 2'b00} +: 4];
    assign w_count    = (w_nibble == 4'd0) ? 4'd1 : w_nibble;

    always_comb begin
        w_limit = 16'(GAP_TICKS - 1);
        case (r_state)
            c_ST_ON:  w_limit = 16'(ON_TICKS - 1);
            c_ST_OFF: w_limit = 16'(OFF_TICKS - 1);
            default:  ;
        endcase
    end

    assign w_phase_done = w_tick && (r_phase == w_limit);

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            led         <= 1'b0;
            grant       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            r_presc     <= '0;
            r_phase     <= '0;
            r_rr_ptr    <= '0;
            r_remaining <= '0;
`ifdef LED_IDLE_HEARTBEAT_EN
            r_hb_cnt    <= '0;
`endif
        end else begin
            done    <= 1'b0;
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            if (w_tick) begin
                r_phase <= r_phase + 16'd1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_state     <= c_ST_ON;
                        grant       <= NREQ'(1) << w_winner;
                        busy        <= 1'b1;
                        led         <= 1'b1;
                        r_remaining <= w_count;
                        r_rr_ptr    <= w_next_ptr;
                        r_presc     <= '0;
                        r_phase     <= '0;
                    end
`ifdef LED_IDLE_HEARTBEAT_EN
                    else if (w_tick) begin
                        if (r_hb_cnt == c_HB_MAX) begin
                            r_hb_cnt <= '0;
                            led      <= ~led;
                        end else begin
                            r_hb_cnt <= r_hb_cnt + 16'd1;
                        end
                    end
`endif
                end

                default: begin
                    // Owner withdrawing its request aborts without a done pulse.
                    if (!w_owner_req) begin
                        r_state     <= c_ST_IDLE;
                        led         <= 1'b0;
                        grant       <= '0;
                        busy        <= 1'b0;
                        r_phase     <= '0;
                        r_remaining <= '0;
`ifdef LED_IDLE_HEARTBEAT_EN
                        r_hb_cnt    <= '0;
`endif
                    end else if (w_phase_done) begin
                        r_phase <= '0;
                        case (r_state)
                            c_ST_ON: begin
                                r_state     <= c_ST_OFF;
                                led         <= 1'b0;
                                r_remaining <= r_remaining - 4'd1;
                            end
                            c_ST_OFF: begin
                                if (r_remaining != 4'd0) begin
                                    r_state <= c_ST_ON;
                                    led     <= 1'b1;
                                end else begin
                                    r_state <= c_ST_GAP;
                                end
                            end
                            default: begin
                                r_state  <= c_ST_IDLE;
                                done     <= 1'b1;
                                grant    <= '0;
                                busy     <= 1'b0;
`ifdef LED_IDLE_HEARTBEAT_EN
                                r_hb_cnt <= '0;
`endif
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_sched
// Description : Self-checking bench for led_pattern_sched with a timeline
//               model of arbitration, blink codes, abandon and heartbeat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_sched;

    localparam int OSC  = 100;
    localparam int THZ  = 10;
    localparam int NR   = 4;
    localparam int ONT  = 2;
    localparam int OFFT = 2;
    localparam int GAPT = 3;
    localparam int DIV  = OSC / THZ;
    localparam int ONC  = DIV * ONT;
    localparam int PER  = DIV * (ONT + OFFT);
    localparam int GAPC = DIV * GAPT;
    localparam int HBC  = DIV * (THZ / 2);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] blink_cnt = '0;
    logic        led;
    logic [3:0]  grant;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    led_pattern_sched #(
        .OSC_CLOCK (OSC),
        .TICK_HZ   (THZ),
        .NREQ      (NR),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .GAP_TICKS (GAPT)
    ) dut (
        .in_clk    (clk),
        .reset     (rst),
        .req       (req),
        .blink_cnt (blink_cnt),
        .led       (led),
        .grant     (grant),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a sequence is its grant edge plus flash count; outputs follow from elapsed edges.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_idle_known = 1'b1;
    int m_e = 0;
    int m_start = 0;
    int m_n = 1;
    int m_owner = 0;
    int m_ptr = 0;
    int m_idle_since = 0;
    int m_w = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_idle_known = 1'b1;
            m_e = 0; m_start = 0; m_n = 1; m_owner = 0; m_ptr = 0; m_idle_since = 0;
        end else begin
            m_e = m_e + 1;
            m_done = 1'b0;
            if (m_busy) begin
                if (!req[m_owner]) begin
                    m_busy = 1'b0; m_idle_since = m_e; m_idle_known = 1'b0;
                end else if (m_e - m_start == m_n * PER + GAPC) begin
                    m_busy = 1'b0; m_done = 1'b1; m_idle_since = m_e; m_idle_known = 1'b1;
                end
            end else begin
                for (int k = 0; k < NR; k++) begin
                    m_w = (m_ptr + k) % NR;
                    if (!m_busy && req[m_w]) begin
                        m_busy  = 1'b1;
                        m_owner = m_w;
                        m_start = m_e;
                        m_n     = (blink_cnt[4*m_w +: 4] == 4'd0) ? 1 : int'(blink_cnt[4*m_w +: 4]);
                        m_ptr   = (m_w + 1) % NR;
                    end
                end
            end
        end
    end

    int c_t;
    always @(negedge clk) begin
        if (!rst) begin
            c_t = m_e - m_start;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("grant", 32'(grant), m_busy ? (32'd1 << m_owner) : 32'd0);
            chk("done", 32'(done), 32'(m_done));
            if (m_busy) begin
                chk("led_seq", 32'(led), 32'((c_t < m_n * PER) && (c_t % PER < ONC)));
            end else begin
`ifdef LED_IDLE_HEARTBEAT_EN
                if (m_idle_known)
                    chk("led_hb", 32'(led), 32'(((m_e - m_idle_since) / HBC) % 2));
`else
                chk("led_idle", 32'(led), 32'd0);
`endif
            end
        end
    end

    task automatic wait_grant(output logic [3:0] g, output int lat);
        lat = 0;
        while (grant == 4'b0 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        g = grant;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [3:0] g;
    logic [3:0] order [5];
    logic       led_prev;
    int         lat, n, pulses, toggles;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Round-robin with all four requesting, one flash each
        blink_cnt = 16'h1111;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, lat);
            order[i] = g;
            wait_done(n);
            chk("rr_done_at", 32'(n), 32'd70);
            if (i == 4) req = 4'b0000;
        end
        chk("rr_order0", 32'(order[0]), 32'h1);
        chk("rr_order1", 32'(order[1]), 32'h2);
        chk("rr_order2", 32'(order[2]), 32'h4);
        chk("rr_order3", 32'(order[3]), 32'h8);
        chk("rr_order4", 32'(order[4]), 32'h1);

        // Single requester, two flashes
        @(negedge clk);
        blink_cnt = 16'h0002;
        req = 4'b0001;
        wait_grant(g, lat);
        chk("single_grant", 32'(g), 32'h1);
        chk("single_latency", 32'(lat), 32'd1);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 19) chk("single_led19", 32'(led), 32'd1);
            if (n == 20) chk("single_led20", 32'(led), 32'd0);
            if (n == 40) chk("single_led40", 32'(led), 32'd1);
            if (n == 60) chk("single_led60", 32'(led), 32'd0);
        end
        chk("single_done_at", 32'(n), 32'd110);
        chk("single_grant_clear", 32'(grant), 32'd0);
        req = 4'b0000;

        // Zero count behaves as one flash
        @(negedge clk);
        blink_cnt = 16'h0000;
        req = 4'b0010;
        wait_grant(g, lat);
        chk("zero_grant", 32'(g), 32'h2);
        wait_done(n);
        chk("zero_done_at", 32'(n), 32'd70);
        req = 4'b0000;

        // Abandon: req[2] drops during OFF, req[3] waiting
        @(negedge clk);
        blink_cnt = 16'h1030;
        req = 4'b1100;
        wait_grant(g, lat);
        chk("abandon_grant", 32'(g), 32'h4);
        repeat (25) @(negedge clk);
        chk("abandon_off_led", 32'(led), 32'd0);
        chk("abandon_off_busy", 32'(busy), 32'd1);
        req = 4'b1000;
        @(negedge clk);
        chk("abandon_grant0", 32'(grant), 32'd0);
        chk("abandon_busy0", 32'(busy), 32'd0);
        chk("abandon_nodone", 32'(done), 32'd0);
        @(negedge clk);
        chk("abandon_next_grant", 32'(grant), 32'h8);
        wait_done(n);
        chk("req3_done_at", 32'(n), 32'd70);
        req = 4'b0000;

        // Asynchronous reset mid-ON
        @(negedge clk);
        blink_cnt = 16'h0003;
        req = 4'b0001;
        wait_grant(g, lat);
        chk("rst_seq_grant", 32'(g), 32'h1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led), 32'd0);
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        toggles = 0;
        led_prev = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done) pulses++;
            if (led !== led_prev) toggles++;
            led_prev = led;
        end
        chk("rst_no_done", 32'(pulses), 32'd0);
        chk("rst_idle_grant", 32'(grant), 32'd0);
`ifdef LED_IDLE_HEARTBEAT_EN
        chk("hb_toggles", 32'(toggles), 32'd3);
`else
        chk("idle_no_toggles", 32'(toggles), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
